// File: rtl/car_sprite_engine.sv
// car_sprite_engine: two-stage pipelined hit test of one screen pixel against N_CARS race-car sprites.
// Wheel animation (frame counter + hub pattern) is built only when CAR_SPRITE_ANIM_EN is defined.
module car_sprite_engine #(
    parameter int  N_CARS     = 4,
    parameter int  COORD_W    = 10,
    parameter int  SCALE_LOG2 = 0,
    parameter int  ANIM_DIV   = 8,
    localparam int ID_W       = (N_CARS > 1) ? $clog2(N_CARS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_tick,
    input  logic [N_CARS-1:0]           car_en,
    input  logic [N_CARS*COORD_W-1:0]   car_x,
    input  logic [N_CARS*COORD_W-1:0]   car_y,
    input  logic                        pix_valid,
    input  logic [COORD_W-1:0]          pix_x,
    input  logic [COORD_W-1:0]          pix_y,
    output logic                        out_valid,
    output logic                        hit,
    output logic [ID_W-1:0]             hit_id,
    output logic [COORD_W-1:0]          out_x,
    output logic [COORD_W-1:0]          out_y,
    output logic                        anim_phase
);

    localparam logic [COORD_W:0] SPAN = (COORD_W+1)'(30 << SCALE_LOG2);

    if (N_CARS < 1 || N_CARS > 8) begin : g_bad_n_cars
        $error("car_sprite_engine: N_CARS must be 1..8");
    end
    if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_bad_scale
        $error("car_sprite_engine: SCALE_LOG2 must be 0..2");
    end
    if (ANIM_DIV < 1) begin : g_bad_anim_div
        $error("car_sprite_engine: ANIM_DIV must be >= 1");
    end

    // Solid spans per sprite row, minus wheel cutouts; cutouts show the hub pattern when phase=1.
    function automatic logic sprite_solid(input logic [4:0] sx, input logic [4:0] sy,
                                          input logic phase);
        logic [4:0] lo, hi, l0, h0, l1, h1;
        logic       in_span, in_cut;
        lo = 5'd31; hi = 5'd0;
        l0 = 5'd31; h0 = 5'd0; l1 = 5'd31; h1 = 5'd0;
        case (sy) inside
            5'd5:           begin lo = 5'd8; hi = 5'd21; end
            5'd6:           begin lo = 5'd7; hi = 5'd22; end
            5'd7:           begin lo = 5'd6; hi = 5'd23; end
            [5'd8:5'd10]:   begin lo = 5'd5; hi = 5'd24; end
            [5'd11:5'd13]:  begin lo = 5'd4; hi = 5'd25; end
            5'd14:          begin lo = 5'd3; hi = 5'd26; end
            [5'd15:5'd26]:  begin lo = 5'd2; hi = 5'd27; end
            default: ;
        endcase
        case (sy)
            5'd21, 5'd26: begin l0 = 5'd5; h0 = 5'd9;  l1 = 5'd20; h1 = 5'd24; end
            5'd22, 5'd25: begin l0 = 5'd6; h0 = 5'd10; l1 = 5'd19; h1 = 5'd23; end
            5'd23, 5'd24: begin l0 = 5'd7; h0 = 5'd11; l1 = 5'd18; h1 = 5'd22; end
            default: ;
        endcase
        in_span = (sx >= lo) && (sx <= hi);
        in_cut  = ((sx >= l0) && (sx <= h0)) || ((sx >= l1) && (sx <= h1));
        return in_span && (!in_cut || (phase && (sx[0] == sy[0])));
    endfunction

    logic [N_CARS-1:0]          act_en_q, act_en_d;
    logic [N_CARS*COORD_W-1:0]  act_x_q, act_x_d, act_y_q, act_y_d;

    logic                       s1_valid_q, s1_valid_d;
    logic [N_CARS-1:0]          s1_in_q, s1_in_d;
    logic [N_CARS-1:0][4:0]     s1_sx_q, s1_sx_d, s1_sy_q, s1_sy_d;
    logic [COORD_W-1:0]         s1_x_q, s1_x_d, s1_y_q, s1_y_d;

    logic                       out_valid_q, out_valid_d;
    logic                       hit_q, hit_d;
    logic [ID_W-1:0]            hit_id_q, hit_id_d;
    logic [COORD_W-1:0]         out_x_q, out_x_d, out_y_q, out_y_d;

    logic                       anim_phase_cur;

    logic [COORD_W-1:0]         ax, ay;
    logic [COORD_W:0]           dx, dy;

`ifdef CAR_SPRITE_ANIM_EN
    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [CNT_W-1:0] anim_cnt_q, anim_cnt_d;
    logic             anim_phase_q, anim_phase_d;

    always_comb begin
        anim_cnt_d   = anim_cnt_q;
        anim_phase_d = anim_phase_q;
        if (frame_tick) begin
            if (anim_cnt_q == CNT_W'(ANIM_DIV - 1)) begin
                anim_cnt_d   = '0;
                anim_phase_d = ~anim_phase_q;
            end else begin
                anim_cnt_d = anim_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            anim_cnt_q   <= '0;
            anim_phase_q <= 1'b0;
        end else begin
            anim_cnt_q   <= anim_cnt_d;
            anim_phase_q <= anim_phase_d;
        end
    end

    assign anim_phase_cur = anim_phase_q;
`else
    assign anim_phase_cur = 1'b0;
`endif

    // Shadow registers load only at frame start so a frame never sees torn positions.
    always_comb begin
        act_en_d = act_en_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        if (frame_tick) begin
            act_en_d = car_en;
            act_x_d  = car_x;
            act_y_d  = car_y;
        end
    end

    // Stage 1: per-car box test and sprite-space coordinates.
    always_comb begin
        s1_valid_d = pix_valid;
        s1_x_d     = pix_x;
        s1_y_d     = pix_y;
        s1_in_d    = '0;
        s1_sx_d    = '0;
        s1_sy_d    = '0;
        ax = '0;
        ay = '0;
        dx = '0;
        dy = '0;
        for (int i = 0; i < N_CARS; i++) begin
            ax = act_x_q[i*COORD_W +: COORD_W];
            ay = act_y_q[i*COORD_W +: COORD_W];
            dx = {1'b0, pix_x} - {1'b0, ax};
            dy = {1'b0, pix_y} - {1'b0, ay};
            s1_in_d[i] = act_en_q[i] && (pix_x >= ax) && (pix_y >= ay)
                         && (dx < SPAN) && (dy < SPAN);
            s1_sx_d[i] = 5'(dx >> SCALE_LOG2);
            s1_sy_d[i] = 5'(dy >> SCALE_LOG2);
        end
    end

    // Stage 2: shape lookup and priority; descending scan so the lowest index wins.
    always_comb begin
        out_valid_d = s1_valid_q;
        hit_d       = hit_q;
        hit_id_d    = hit_id_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        if (s1_valid_q) begin
            hit_d    = 1'b0;
            hit_id_d = '0;
            out_x_d  = s1_x_q;
            out_y_d  = s1_y_q;
            for (int i = N_CARS - 1; i >= 0; i--) begin
                if (s1_in_q[i] && sprite_solid(s1_sx_q[i], s1_sy_q[i], anim_phase_cur)) begin
                    hit_d    = 1'b1;
                    hit_id_d = ID_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_en_q    <= '0;
            act_x_q     <= '0;
            act_y_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_in_q     <= '0;
            s1_sx_q     <= '0;
            s1_sy_q     <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            out_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_id_q    <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            act_en_q    <= act_en_d;
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
            s1_valid_q  <= s1_valid_d;
            s1_in_q     <= s1_in_d;
            s1_sx_q     <= s1_sx_d;
            s1_sy_q     <= s1_sy_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            out_valid_q <= out_valid_d;
            hit_q       <= hit_d;
            hit_id_q    <= hit_id_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign hit        = hit_q;
    assign hit_id     = hit_id_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign anim_phase = anim_phase_cur;

endmodule

// File: tb/tb_car_sprite_engine.sv
// Bench for car_sprite_engine: directed vector table, corner sequences, and random traffic
// checked against a frame-level reference model on a scale-0 and a scale-1 instance.
module tb_car_sprite_engine;
    localparam int N    = 4;
    localparam int CW   = 10;
    localparam int ADIV = 2;

    logic            clk = 1'b0;
    logic            reset, frame_tick, pix_valid;
    logic [N-1:0]    car_en;
    logic [N*CW-1:0] car_x, car_y;
    logic [CW-1:0]   pix_x, pix_y;
    logic            ov0, hit0, ph0, ov1, hit1, ph1;
    logic [1:0]      id0, id1;
    logic [CW-1:0]   ox0, oy0, ox1, oy1;

    always #5 clk = ~clk;

    car_sprite_engine #(.N_CARS(N), .COORD_W(CW), .SCALE_LOG2(0), .ANIM_DIV(ADIV)) dut0 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .car_en(car_en),
        .car_x(car_x), .car_y(car_y), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .out_valid(ov0), .hit(hit0), .hit_id(id0), .out_x(ox0), .out_y(oy0),
        .anim_phase(ph0));

    car_sprite_engine #(.N_CARS(N), .COORD_W(CW), .SCALE_LOG2(1), .ANIM_DIV(ADIV)) dut1 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .car_en(car_en),
        .car_x(car_x), .car_y(car_y), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .out_valid(ov1), .hit(hit1), .hit_id(id1), .out_x(ox1), .out_y(oy1),
        .anim_phase(ph1));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: latched car set, animation, one query in flight, visible result.
    int m_en[N], m_ax[N], m_ay[N];
    int m_cnt   = 0;
    bit m_phase = 1'b0;
    bit p1_valid = 1'b0;
    int p1_x = 0, p1_y = 0;
    bit p1_h[2][2];
    int p1_id[2][2];
    bit e_valid = 1'b0;
    int e_x = 0, e_y = 0;
    bit e_hit[2];
    int e_id[2];

    typedef struct {
        int px;
        int py;
        bit exp_hit;
        int exp_id;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit sprite_solid(input int sx, input int sy, input bit ph);
        int lo, hi, k;
        bit cut;
        lo = 1; hi = 0; cut = 1'b0;
        if (sy == 5)                 begin lo = 8; hi = 21; end
        else if (sy == 6)            begin lo = 7; hi = 22; end
        else if (sy == 7)            begin lo = 6; hi = 23; end
        else if (sy >= 8 && sy <= 10)  begin lo = 5; hi = 24; end
        else if (sy >= 11 && sy <= 13) begin lo = 4; hi = 25; end
        else if (sy == 14)           begin lo = 3; hi = 26; end
        else if (sy >= 15 && sy <= 26) begin lo = 2; hi = 27; end
        if (sy >= 21 && sy <= 26) begin
            k = (sy <= 23) ? sy - 21 : 26 - sy;
            cut = (sx >= 5 + k && sx <= 9 + k) || (sx >= 20 - k && sx <= 24 - k);
        end
        if (sx < lo || sx > hi) return 1'b0;
        if (cut) return ph && ((sx % 2) == (sy % 2));
        return 1'b1;
    endfunction

    function automatic void model_hit(input int px, input int py, input int s, input bit ph,
                                      output bit h, output int id);
        int span;
        span = 30 << s;
        h = 1'b0;
        id = 0;
        for (int i = 0; i < N; i++) begin
            if (!h && m_en[i] != 0 && px >= m_ax[i] && py >= m_ay[i]
                && px - m_ax[i] < span && py - m_ay[i] < span
                && sprite_solid((px - m_ax[i]) >> s, (py - m_ay[i]) >> s, ph)) begin
                h  = 1'b1;
                id = i;
            end
        end
    endfunction

    task automatic check_all();
        chk("valid_s0", ov0,  e_valid);
        chk("hit_s0",   hit0, e_hit[0]);
        chk("id_s0",    id0,  e_id[0]);
        chk("x_s0",     ox0,  e_x);
        chk("y_s0",     oy0,  e_y);
        chk("phase_s0", ph0,  m_phase);
        chk("valid_s1", ov1,  e_valid);
        chk("hit_s1",   hit1, e_hit[1]);
        chk("id_s1",    id1,  e_id[1]);
        chk("x_s1",     ox1,  e_x);
        chk("y_s1",     oy1,  e_y);
        chk("phase_s1", ph1,  m_phase);
    endtask

    // One clock: drive inputs, advance the model across the edge, check at the falling edge.
    task automatic cyc(input bit rst, input bit tk, input bit pv, input int px, input int py);
        bit h;
        int id;
        reset      = rst;
        frame_tick = tk;
        pix_valid  = pv;
        pix_x      = px[CW-1:0];
        pix_y      = py[CW-1:0];
        @(posedge clk);
        if (rst) begin
            p1_valid = 1'b0; e_valid = 1'b0; e_x = 0; e_y = 0;
            e_hit[0] = 1'b0; e_hit[1] = 1'b0; e_id[0] = 0; e_id[1] = 0;
            m_cnt = 0; m_phase = 1'b0;
            for (int i = 0; i < N; i++) begin m_en[i] = 0; m_ax[i] = 0; m_ay[i] = 0; end
        end else begin
            e_valid = p1_valid;
            if (p1_valid) begin
                e_x = p1_x;
                e_y = p1_y;
                for (int s = 0; s < 2; s++) begin
                    e_hit[s] = p1_h[s][m_phase];
                    e_id[s]  = p1_id[s][m_phase];
                end
            end
            p1_valid = pv;
            p1_x = px;
            p1_y = py;
            for (int s = 0; s < 2; s++)
                for (int p = 0; p < 2; p++) begin
                    model_hit(px, py, s, p[0], h, id);
                    p1_h[s][p]  = h;
                    p1_id[s][p] = id;
                end
            if (tk) begin
                for (int i = 0; i < N; i++) begin
                    m_en[i] = int'(car_en[i]);
                    m_ax[i] = int'(car_x[i*CW +: CW]);
                    m_ay[i] = int'(car_y[i*CW +: CW]);
                end
`ifdef CAR_SPRITE_ANIM_EN
                if (m_cnt == ADIV - 1) begin
                    m_cnt   = 0;
                    m_phase = !m_phase;
                end else begin
                    m_cnt++;
                end
`endif
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic set_car(input int i, input bit en, input int x, input int y);
        car_en[i] = en;
        car_x[i*CW +: CW] = x[CW-1:0];
        car_y[i*CW +: CW] = y[CW-1:0];
    endtask

    // Issue one query, idle one cycle, and check the result now on the outputs.
    task automatic query_expect(input string nm, input int px, input int py, input int sel,
                                input bit exp_hit, input int exp_id);
        cyc(1'b0, 1'b0, 1'b1, px, py);
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        chk({nm, "_valid"}, (sel == 0) ? ov0 : ov1, 1);
        chk({nm, "_hit"},   (sel == 0) ? hit0 : hit1, exp_hit);
        if (exp_hit) chk({nm, "_id"}, (sel == 0) ? id0 : id1, exp_id);
    endtask

    bit anim_on;
    int nvalid;

    initial begin
`ifdef CAR_SPRITE_ANIM_EN
        anim_on = 1'b1;
`else
        anim_on = 1'b0;
`endif
        tbl[0] = '{110, 60, 1'b1, 0};
        tbl[1] = '{100, 50, 1'b0, 0};
        tbl[2] = '{107, 71, 1'b0, 0};
        tbl[3] = '{129, 60, 1'b0, 0};
        tbl[4] = '{124, 60, 1'b1, 0};
        tbl[5] = '{99,  60, 1'b0, 0};

        car_en = '0; car_x = '0; car_y = '0;
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        chk("rst_valid", ov0, 0);
        chk("rst_hit",   hit0, 0);
        chk("rst_phase", ph0, 0);

        set_car(0, 1'b1, 100, 50);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        for (int v = 0; v < 6; v++)
            query_expect($sformatf("vec%0d", v), tbl[v].px, tbl[v].py, 0,
                         tbl[v].exp_hit, tbl[v].exp_id);

        // Second tick: phase toggles when animation is built in.
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        chk("anim_phase_after2", ph0, anim_on);
        query_expect("anim_hub",  107, 71, 0, anim_on, 0);
        query_expect("anim_gap",  108, 71, 0, 1'b0, 0);

        // Shadowing.
        set_car(0, 1'b1, 300, 50);
        query_expect("shadow_hold", 110, 60, 0, 1'b1, 0);
        cyc(1'b0, 1'b1, 1'b1, 110, 60);
        cyc(1'b0, 1'b0, 1'b1, 110, 60);
        chk("shadow_same_cycle", hit0, 1);
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        chk("shadow_after_tick", hit0, 0);

        // Priority overlap.
        set_car(1, 1'b1, 200, 200);
        set_car(2, 1'b1, 200, 200);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        query_expect("prio_12", 215, 215, 0, 1'b1, 1);
        set_car(1, 1'b0, 200, 200);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        query_expect("prio_2", 215, 215, 0, 1'b1, 2);

        // Scaling on the scale-1 instance.
        set_car(0, 1'b1, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        query_expect("scale_edge", 59, 40, 1, 1'b0, 0);
        query_expect("scale_in",   10, 40, 1, 1'b1, 0);

        // Back-to-back stream.
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 5 + i * 3, 10 + i);
            nvalid += int'(ov0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 0, 0);
            nvalid += int'(ov0);
        end
        chk("stream_count", nvalid, 10);

        // Reset with two queries in flight.
        cyc(1'b0, 1'b0, 1'b1, 10, 10);
        cyc(1'b1, 1'b0, 1'b1, 12, 12);
        chk("flush_valid", ov0, 0);
        chk("flush_x",     ox0, 0);
        chk("flush_hit",   hit0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 0, 0);
            chk("flush_no_emit", ov0, 0);
        end

        // Random traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            bit rst, tk, pv;
            int px, py;
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        set_car(i, 1'($urandom_range(0, 1)), $urandom_range(0, 1023),
                                $urandom_range(0, 1023));
                    else
                        set_car(i, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 150),
                                $urandom_range(0, 150));
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            tk  = ($urandom_range(0, 9) == 0);
            pv  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
            end else begin
                px = $urandom_range(0, 220);
                py = $urandom_range(0, 220);
            end
            cyc(rst, tk, pv, px, py);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
